key_expansion_seq: RTL and testbench

//  Sequential AES-128 key-schedule controller driving one combinational roundKey instance.
//  - Iterates the cipher key over NUM_ROUNDS rounds, one round per clock.
//  - Stores every round key in an internal buffer.
//  - Serves the stored keys to the cipher datapath through a registered read port.
//  - Sits between the key-load interface and the encryption round pipeline.

---
 rtl/key_expansion_seq.sv | 167 ++++++++++++++++
 tb/tb_key_expansion_seq.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_expansion_seq.sv
// AES-128 key-schedule sequencer: one round key per clock into a buffer with a registered read port; optional KEYEXP_SKIP_SAME_EN skips re-expanding an unchanged key.
// Latency: done pulses NUM_ROUNDS+1 cycles after the start edge; rd_data/rd_valid one cycle after rd_en.
// Backpressure: none; start is dropped unless IDLE, reads are always served.
module key_expansion_seq #(
  parameter int KEY_W      = 128,
  parameter int NUM_ROUNDS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [KEY_W-1:0] key_in,
  output logic             busy,
  output logic             done,
  output logic             keys_valid,
  input  logic             rd_en,
  input  logic [3:0]       rd_idx,
  output logic [KEY_W-1:0] rd_data,
  output logic             rd_valid
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXPAND = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // S-box, byte 0x00 in the most significant position.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[(255 - int'(b)) * 8 +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] round);
    logic [7:0] r;
    case (round)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [127:0] round_key(input logic [127:0] key, input logic [3:0] round);
    logic [31:0] rot, t, n0, n1, n2, n3;
    rot = {key[23:0], key[31:24]};
    t   = {sbox(rot[31:24]) ^ rcon(round), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    n0  = key[127:96] ^ t;
    n1  = key[95:64]  ^ n0;
    n2  = key[63:32]  ^ n1;
    n3  = key[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  logic [1:0]       state_q, state_d;
  logic [3:0]       round_cnt_q, round_cnt_d;
  logic             done_q, done_d;
  logic             keys_valid_q, keys_valid_d;
  logic             rd_valid_q, rd_valid_d;
  logic [KEY_W-1:0] rd_data_q, rd_data_d;
  logic [KEY_W-1:0] rk_q [0:NUM_ROUNDS];
  logic [KEY_W-1:0] rk_d [0:NUM_ROUNDS];
  logic [KEY_W-1:0] prev_key, next_key, rd_sel;
  logic             skip_same;

`ifdef KEYEXP_SKIP_SAME_EN
  assign skip_same = keys_valid_q && (key_in == rk_q[0]);
`else
  assign skip_same = 1'b0;
`endif

  always_comb begin
    prev_key = '0;
    for (int i = 0; i < NUM_ROUNDS; i++) begin
      if (round_cnt_q == 4'(i + 1)) prev_key = rk_q[i];
    end
  end

  assign next_key = round_key(prev_key, round_cnt_q);

  always_comb begin
    state_d      = state_q;
    round_cnt_d  = round_cnt_q;
    keys_valid_d = keys_valid_q;
    done_d       = 1'b0;
    rk_d         = rk_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (skip_same) begin
            state_d = ST_DONE;
          end else begin
            rk_d[0]      = key_in;
            round_cnt_d  = 4'd1;
            keys_valid_d = 1'b0;
            state_d      = ST_EXPAND;
          end
        end
      end
      ST_EXPAND: begin
        for (int i = 1; i <= NUM_ROUNDS; i++) begin
          if (round_cnt_q == 4'(i)) rk_d[i] = next_key;
        end
        if (round_cnt_q == 4'(NUM_ROUNDS)) state_d = ST_DONE;
        else                              round_cnt_d = round_cnt_q + 4'd1;
      end
      ST_DONE: begin
        done_d       = 1'b1;
        keys_valid_d = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read sees the buffer as it stood before this edge: no write bypass.
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i <= NUM_ROUNDS; i++) begin
      if (rd_idx == 4'(i)) rd_sel = rk_q[i];
    end
    rd_valid_d = rd_en;
    rd_data_d  = rd_en ? rd_sel : rd_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      round_cnt_q  <= '0;
      done_q       <= 1'b0;
      keys_valid_q <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      for (int i = 0; i <= NUM_ROUNDS; i++) rk_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      round_cnt_q  <= round_cnt_d;
      done_q       <= done_d;
      keys_valid_q <= keys_valid_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
      for (int i = 0; i <= NUM_ROUNDS; i++) rk_q[i] <= rk_d[i];
    end
  end

  assign busy       = (state_q == ST_EXPAND);
  assign done       = done_q;
  assign keys_valid = keys_valid_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;

endmodule

// File: tb/tb_key_expansion_seq.sv
// Scoreboard bench for key_expansion_seq: reference schedule built from GF(2^8) arithmetic and the FIPS-197 word recurrence.
module tb_key_expansion_seq;
  localparam int NR = 10;
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         busy, done, keys_valid, rd_en, rd_valid;
  logic [3:0]   rd_idx;
  logic [127:0] rd_data;

  key_expansion_seq #(.KEY_W(128), .NUM_ROUNDS(NR)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in),
    .busy(busy), .done(done), .keys_valid(keys_valid),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_rd[$];
  int           exp_done[$];
  logic [7:0]   sb [0:255];
  logic [127:0] mbuf [0:NR];
  logic [127:0] pk [0:NR];
  logic         pending;
  int           e0;
  logic         mkv;
  logic [127:0] mon_rd;
  int           mon_dc;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from first principles: multiplicative inverse then affine map.
  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
      if (x == 0) inv = 8'h00;
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sb[x] = s;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic compute_sched(input logic [127:0] k);
    logic [31:0] w [0:4*NR+3];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 4 * (NR + 1); i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++) pk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Entry idx of the pending schedule is written at edge e0+idx; later edges see it.
  function automatic logic [127:0] model_rd(input int idx, input int redge);
    if (idx > NR) return '0;
    if (pending && redge > e0 + idx) return pk[idx];
    return mbuf[idx];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_issue(input int idx);
    rd_en  = 1'b1;
    rd_idx = 4'(idx);
    exp_rd.push_back(model_rd(idx, cyc + 1));
    tick();
  endtask

  task automatic rd_lit(input int idx, input logic [127:0] val);
    rd_en  = 1'b1;
    rd_idx = 4'(idx);
    exp_rd.push_back(val);
    tick();
  endtask

  task automatic sweep();
    for (int i = 0; i <= NR; i++) rd_issue(i);
    rd_en = 1'b0;
    tick();
  endtask

  task automatic start_key(input logic [127:0] k);
    logic skip;
    skip = 1'b0;
`ifdef KEYEXP_SKIP_SAME_EN
    skip = mkv && (k == mbuf[0]);
`endif
    if (skip) begin
      exp_done.push_back(cyc + 2);
    end else begin
      compute_sched(k);
      pending = 1'b1;
      e0      = cyc + 1;
      mkv     = 1'b0;
      exp_done.push_back(cyc + NR + 2);
    end
    start  = 1'b1;
    key_in = k;
    tick();
    start  = 1'b0;
  endtask

  task automatic wait_q(input int remaining);
    int n = 0;
    while (exp_done.size() > remaining && n < 60) begin
      tick();
      n++;
    end
    if (exp_done.size() > remaining) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: %0d done pulses still outstanding, required %0d", exp_done.size(), remaining);
      while (exp_done.size() > remaining) void'(exp_done.pop_front());
    end
  endtask

  task automatic wait_done();
    wait_q(0);
    if (pending) begin
      for (int r = 0; r <= NR; r++) mbuf[r] = pk[r];
      pending = 1'b0;
    end
    mkv = 1'b1;
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_valid) begin
        if (exp_rd.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_unexpected: rd_valid high with data %h, required no read outstanding", rd_data);
        end else begin
          mon_rd = exp_rd.pop_front();
          check("rd_data", rd_data, mon_rd);
        end
      end
      if (done) begin
        if (exp_done.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected: done high at cycle %0d, required no pulse", cyc);
        end else begin
          mon_dc = exp_done.pop_front();
          check("done_cycle", 128'(cyc), 128'(mon_dc));
        end
      end
    end
  end

  initial begin
    logic [127:0] ka, kb;
    int k0;
    rst_n = 1'b0; start = 1'b0; key_in = '0; rd_en = 1'b0; rd_idx = '0;
    pending = 1'b0; mkv = 1'b0; e0 = 0;
    for (int r = 0; r <= NR; r++) mbuf[r] = '0;
    build_sbox();
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 128'(busy), 0);
    check("reset_done", 128'(done), 0);
    check("reset_keys_valid", 128'(keys_valid), 0);
    check("reset_rd_valid", 128'(rd_valid), 0);
    check("reset_rd_data", rd_data, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // FIPS-197 known answer
    start_key(FIPS_KEY);
    check("busy_expand", 128'(busy), 1);
    wait_done();
    check("fips_keys_valid", 128'(keys_valid), 1);
    rd_lit(1, 128'ha0fafe1788542cb123a339392a6c7605);
    rd_lit(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    sweep();

    // all-zero key
    start_key('0);
    wait_done();
    rd_lit(1, 128'h62636363626363636263636362636363);
    rd_lit(0, '0);
    rd_en = 1'b0;
    tick();
    check("zero_keys_valid", 128'(keys_valid), 1);

    // start while busy is dropped
    ka = rand_key();
    kb = rand_key();
    start_key(ka);
    tick(); tick();
    start = 1'b1; key_in = kb;
    tick();
    start = 1'b0;
    wait_done();
    sweep();

    // reset at round_cnt = 5 aborts the expansion
    start_key(rand_key());
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    exp_done.delete();
    pending = 1'b0;
    mkv = 1'b0;
    for (int r = 0; r <= NR; r++) mbuf[r] = '0;
    check("abort_busy", 128'(busy), 0);
    check("abort_keys_valid", 128'(keys_valid), 0);
    tick(); tick();
    @(negedge clk) rst_n = 1'b1;
    tick();
    sweep();
    start_key(rand_key());
    wait_done();
    sweep();

    // out-of-range indices, then hold
    rd_issue(11);
    rd_issue(15);
    rd_issue(3);
    rd_en = 1'b0;
    tick();
    check("hold_rd_valid", 128'(rd_valid), 0);
    check("hold_rd_data", rd_data, mbuf[3]);

    // start held through EXPAND and DONE is honoured on the first IDLE edge
    ka = rand_key();
    kb = rand_key();
    k0 = cyc;
    start_key(ka);
    start = 1'b1; key_in = kb;
    exp_done.push_back(k0 + 2 * NR + 4);
    wait_q(1);
    start = 1'b0;
    compute_sched(kb);
    pending = 1'b1;
    e0 = k0 + NR + 3;
    mkv = 1'b0;
    wait_done();
    sweep();

    // random keys with random reads during expansion
    for (int n = 0; n < 4; n++) begin
      start_key(rand_key());
      for (int c = 0; c < NR + 2; c++) rd_issue(int'($urandom_range(0, 15)));
      rd_en = 1'b0;
      wait_done();
      check("rand_keys_valid", 128'(keys_valid), 1);
    end

    // same key started twice
    start_key(FIPS_KEY);
    wait_done();
    start_key(FIPS_KEY);
`ifdef KEYEXP_SKIP_SAME_EN
    check("same_key_busy", 128'(busy), 0);
`else
    check("same_key_busy", 128'(busy), 1);
`endif
    wait_done();
    rd_lit(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    rd_en = 1'b0;
    tick();
    tick();

    check("rd_queue_drained", 128'(exp_rd.size()), 0);
    check("done_queue_drained", 128'(exp_done.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
